present_round_ctrl: RTL and testbench

//   Iterative PRESENT-80 encryption controller. Owns the 64-bit state and 80-bit key registers.

---
 rtl/present_round_ctrl.sv | 135 +++++++++++++
 tb/tb_present_round_ctrl.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/present_round_ctrl.sv
// Iterative PRESENT-80 encryption controller: one round per clock, then final key whitening.
// Optional debug outputs round_o/busy_o are enabled by defining PRESENT_CTRL_ROUND_OUT_EN.

module present_sbox (
   input  logic [3:0] x_i,
   output logic [3:0] y_o
);
   always_comb begin
      case (x_i)
         4'h0: y_o = 4'hC;
         4'h1: y_o = 4'h5;
         4'h2: y_o = 4'h6;
         4'h3: y_o = 4'hB;
         4'h4: y_o = 4'h9;
         4'h5: y_o = 4'h0;
         4'h6: y_o = 4'hA;
         4'h7: y_o = 4'hD;
         4'h8: y_o = 4'h3;
         4'h9: y_o = 4'hE;
         4'hA: y_o = 4'hF;
         4'hB: y_o = 4'h8;
         4'hC: y_o = 4'h4;
         4'hD: y_o = 4'h7;
         4'hE: y_o = 4'h1;
         default: y_o = 4'h2;
      endcase
   end
endmodule

module present_round_ctrl #(
   parameter int NUM_ROUNDS = 31
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        in_valid_i,
   output logic        in_ready_o,
   input  logic [63:0] plaintext_i,
   input  logic [79:0] key_i,
   output logic        out_valid_o,
   input  logic        out_ready_i,
   output logic [63:0] ciphertext_o
`ifdef PRESENT_CTRL_ROUND_OUT_EN
   ,
   output logic [4:0]  round_o,
   output logic        busy_o
`endif
);

   typedef enum logic [1:0] {IDLE, RUN, DONE} st_e;

   localparam logic [4:0] LAST = 5'(NUM_ROUNDS);

   st_e         st_q, st_d;
   logic [63:0] state_q, state_d;
   logic [79:0] key_q, key_d;
   logic [4:0]  rnd_q, rnd_d;

   logic [63:0] sin, sout, perm;
   logic [79:0] krot, knext;
   logic [3:0]  ksb;

   // Round datapath: key addition, substitution layer, bit permutation
   assign sin = state_q ^ key_q[79:16];

   for (genvar j = 0; j < 16; j++) begin : g_sbox
      present_sbox u_sbox (.x_i(sin[4*j +: 4]), .y_o(sout[4*j +: 4]));
   end

   for (genvar i = 0; i < 63; i++) begin : g_perm
      assign perm[(16*i) % 63] = sout[i];
   end
   assign perm[63] = sout[63];

   // Key schedule: rotate left 61, S-box the top nibble, mix in the round counter
   assign krot = {key_q[18:0], key_q[79:19]};
   present_sbox u_ksbox (.x_i(krot[79:76]), .y_o(ksb));
   assign knext = {ksb, krot[75:20], krot[19:15] ^ rnd_q, krot[14:0]};

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         st_q    <= IDLE;
         state_q <= '0;
         key_q   <= '0;
         rnd_q   <= '0;
      end else begin
         st_q    <= st_d;
         state_q <= state_d;
         key_q   <= key_d;
         rnd_q   <= rnd_d;
      end
   end

   always_comb begin
      st_d        = st_q;
      state_d     = state_q;
      key_d       = key_q;
      rnd_d       = rnd_q;
      in_ready_o  = 1'b0;
      out_valid_o = 1'b0;
      case (st_q)
         IDLE: begin
            in_ready_o = ~rst_i;
            if (in_valid_i) begin
               state_d = plaintext_i;
               key_d   = key_i;
               rnd_d   = 5'd1;
               st_d    = RUN;
            end
         end
         RUN: begin
            state_d = perm;
            key_d   = knext;
            // saturate so DONE reports NUM_ROUNDS+1 without wrapping a 5-bit count
            rnd_d   = (rnd_q == 5'd31) ? 5'd31 : rnd_q + 5'd1;
            if (rnd_q == LAST) st_d = DONE;
         end
         DONE: begin
            out_valid_o = 1'b1;
            if (out_ready_i) begin
               rnd_d = '0;
               st_d  = IDLE;
            end
         end
         default: st_d = IDLE;
      endcase
   end

   assign ciphertext_o = state_q ^ key_q[79:16];

`ifdef PRESENT_CTRL_ROUND_OUT_EN
   assign round_o = rnd_q;
   assign busy_o  = (st_q != IDLE);
`endif

endmodule

// File: tb/tb_present_round_ctrl.sv
// Self-checking bench for present_round_ctrl: known-answer vectors, random vectors against a
// behavioural PRESENT-80 model, back-pressure hold, mid-run reset.

module tb_present_round_ctrl;

   localparam int NR = 31;
   localparam logic [3:0] SBOX [16] = '{4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
                                        4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2};

   logic        clk = 1'b0;
   logic        rst, in_valid, in_ready, out_valid, out_ready;
   logic [63:0] pt, ct, got;
   logic [79:0] key;
`ifdef PRESENT_CTRL_ROUND_OUT_EN
   logic [4:0]  round;
   logic        busy;
`endif

   int cmps = 0;
   int errs = 0;

   present_round_ctrl #(.NUM_ROUNDS(NR)) dut (
      .clk_i(clk), .rst_i(rst),
      .in_valid_i(in_valid), .in_ready_o(in_ready),
      .plaintext_i(pt), .key_i(key),
      .out_valid_o(out_valid), .out_ready_i(out_ready),
      .ciphertext_o(ct)
`ifdef PRESENT_CTRL_ROUND_OUT_EN
      , .round_o(round), .busy_o(busy)
`endif
   );

   always #5 clk = ~clk;

   function automatic logic [63:0] model(input logic [63:0] p, input logic [79:0] k);
      logic [63:0] s, t;
      for (int r = 1; r <= NR; r++) begin
         s = p ^ k[79:16];
         for (int j = 0; j < 16; j++) t[4*j +: 4] = SBOX[s[4*j +: 4]];
         for (int i = 0; i < 63; i++) p[(16*i) % 63] = t[i];
         p[63] = t[63];
         k = {k[18:0], k[79:19]};
         k[79:76] = SBOX[k[79:76]];
         k[19:15] = k[19:15] ^ 5'(r);
      end
      return p ^ k[79:16];
   endfunction

   task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
      cmps++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Called just after a negedge with the DUT idle; returns the ciphertext seen in DONE.
   task automatic run_vec(input logic [63:0] pv, input logic [79:0] kv, input int hold,
                          output logic [63:0] res);
      int n, rdy_seen, bad, rnd_bad;
      logic [63:0] held;
      #1;
      chk("ready_idle", 80'(in_ready), 80'd1);
      in_valid = 1'b1; pt = pv; key = kv;
      @(posedge clk); @(negedge clk);
      in_valid = 1'b0;
      n = 0; rdy_seen = 0; rnd_bad = 0;
`ifdef PRESENT_CTRL_ROUND_OUT_EN
      chk("round_first", 80'(round), 80'd1);
`endif
      while (!out_valid && n < 100) begin
         if (in_ready) rdy_seen = 1;
         in_valid = 1'($urandom_range(0, 1));
         pt = {$urandom, $urandom};
         key = {16'($urandom), $urandom, $urandom};
         @(posedge clk); @(negedge clk);
         n++;
`ifdef PRESENT_CTRL_ROUND_OUT_EN
         if (!out_valid && int'(round) != n + 1) rnd_bad++;
         if (!busy) rnd_bad++;
`endif
      end
      chk("latency", 80'(n), 80'(NR));
      chk("ready_low_run", 80'(rdy_seen), 80'd0);
`ifdef PRESENT_CTRL_ROUND_OUT_EN
      chk("round_seq", 80'(rnd_bad), 80'd0);
      chk("round_done", 80'(round), 80'((NR + 1 > 31) ? 31 : NR + 1));
`endif
      chk("ct_model", 80'(ct), 80'(model(pv, kv)));
      held = ct; bad = 0;
      for (int i = 0; i < hold; i++) begin
         in_valid = 1'($urandom_range(0, 1));
         pt = {$urandom, $urandom};
         @(posedge clk); @(negedge clk);
         if (!out_valid || ct !== held || in_ready) bad++;
      end
      chk("hold_stable", 80'(bad), 80'd0);
      res = ct;
      in_valid = 1'b0; out_ready = 1'b1;
      @(posedge clk); @(negedge clk);
      out_ready = 1'b0;
      chk("valid_drop", 80'(out_valid), 80'd0);
      chk("ready_back", 80'(in_ready), 80'd1);
`ifdef PRESENT_CTRL_ROUND_OUT_EN
      chk("round_idle", 80'(round), 80'd0);
      chk("busy_idle", 80'(busy), 80'd0);
`endif
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; pt = '0; key = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_ready", 80'(in_ready), 80'd0);
      chk("rst_valid", 80'(out_valid), 80'd0);
      chk("rst_ct", 80'(ct), 80'd0);
      rst = 1'b0;

      // known-answer vectors, last two back-to-back
      run_vec(64'h0, 80'h0, 0, got);
      chk("kat_0_0", 80'(got), 80'(64'h5579C1387B228445));
      run_vec(64'h0, {80{1'b1}}, 0, got);
      chk("kat_0_F", 80'(got), 80'(64'hE72C46C0F5945049));
      run_vec({64{1'b1}}, 80'h0, 0, got);
      chk("kat_F_0", 80'(got), 80'(64'hA112FFC72F68417B));
      run_vec({64{1'b1}}, {80{1'b1}}, 0, got);
      chk("kat_F_F", 80'(got), 80'(64'h3333DCD3213210D2));

      // back-pressure for 10 cycles
      run_vec(64'h0, 80'h0, 10, got);
      chk("kat_hold", 80'(got), 80'(64'h5579C1387B228445));

      // reset in the middle of a run
      #1;
      in_valid = 1'b1; pt = {$urandom, $urandom}; key = {16'($urandom), $urandom, $urandom};
      @(posedge clk); @(negedge clk);
      in_valid = 1'b0;
      repeat (14) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk); @(negedge clk);
      chk("midrst_valid", 80'(out_valid), 80'd0);
      chk("midrst_ct", 80'(ct), 80'd0);
      chk("midrst_ready", 80'(in_ready), 80'd0);
      rst = 1'b0;
      run_vec(64'h0, 80'h0, 0, got);
      chk("kat_after_rst", 80'(got), 80'(64'h5579C1387B228445));

      // random vectors against the model
      for (int v = 0; v < 6; v++) begin
         logic [63:0] rp;
         logic [79:0] rk;
         rp = {$urandom, $urandom};
         rk = {16'($urandom), $urandom, $urandom};
         run_vec(rp, rk, int'($urandom_range(0, 5)), got);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmps, errs);
      $finish;
   end

endmodule
